// File: rtl/clocks_meas.sv
// Measures period and high time of NCHAN clock inputs in clk_i ticks.
// Each channel runs its own IDLE/MEAS FSM. A channel with no rising edge for TIMEOUT ticks is flagged as stopped.
module clocks_meas #(
    parameter int unsigned     NCHAN   = 4,
    parameter int unsigned     CW      = 32,
    parameter logic [CW-1:0]   TIMEOUT = {CW{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NCHAN-1:0]      clock_i,
    input  logic                  clear_i,
    output logic [NCHAN*CW-1:0]   period_o,
    output logic [NCHAN*CW-1:0]   high_o,
    output logic [NCHAN-1:0]      valid_o,
    output logic [NCHAN-1:0]      timeout_o
);

    typedef enum logic {ST_IDLE, ST_MEAS} state_e;

    state_e              state_q [NCHAN];
    state_e              state_d [NCHAN];
    logic [CW-1:0]       cnt_q   [NCHAN];
    logic [CW-1:0]       cnt_d   [NCHAN];
    logic [CW-1:0]       hcnt_q  [NCHAN];
    logic [CW-1:0]       hcnt_d  [NCHAN];
    logic [CW-1:0]       hlat_q  [NCHAN];
    logic [CW-1:0]       hlat_d  [NCHAN];
    logic [NCHAN-1:0]    hdone_q, hdone_d;
    logic [NCHAN-1:0]    samp_q, samp_d;
    logic [NCHAN-1:0]    prev_q, prev_d;
    logic [NCHAN-1:0]    valid_q, valid_d;
    logic [NCHAN-1:0]    timeout_q, timeout_d;
    logic [NCHAN*CW-1:0] period_q, period_d;
    logic [NCHAN*CW-1:0] high_q, high_d;
    logic [NCHAN-1:0]    rise_c, fall_c;

    assign rise_c = samp_q & ~prev_q;
    assign fall_c = ~samp_q & prev_q;

    // Per-channel next state; clear_i wins over any edge activity
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        hlat_d    = hlat_q;
        hdone_d   = hdone_q;
        samp_d    = clock_i;
        prev_d    = samp_q;
        valid_d   = '0;
        timeout_d = timeout_q;
        period_d  = period_q;
        high_d    = high_q;
        for (int unsigned n = 0; n < NCHAN; n++) begin
            if (clear_i) begin
                state_d[n]            = ST_IDLE;
                cnt_d[n]              = '0;
                hcnt_d[n]             = '0;
                hlat_d[n]             = '0;
                hdone_d[n]            = 1'b0;
                timeout_d[n]          = 1'b0;
                period_d[n*CW +: CW]  = '0;
                high_d[n*CW +: CW]    = '0;
            end else begin
                case (state_q[n])
                    ST_IDLE: begin
                        cnt_d[n]  = '0;
                        hcnt_d[n] = '0;
                        if (rise_c[n]) begin
                            state_d[n] = ST_MEAS;
                            cnt_d[n]   = CW'(1);
                            hcnt_d[n]  = CW'(1);
                            hlat_d[n]  = '0;
                            hdone_d[n] = 1'b0;
                        end
                    end
                    ST_MEAS: begin
                        if (rise_c[n]) begin
                            period_d[n*CW +: CW] = cnt_q[n];
                            high_d[n*CW +: CW]   = hlat_q[n];
                            valid_d[n]           = 1'b1;
                            timeout_d[n]         = 1'b0;
                            cnt_d[n]             = CW'(1);
                            hcnt_d[n]            = CW'(1);
                            hlat_d[n]            = '0;
                            hdone_d[n]           = 1'b0;
                        end else if (cnt_q[n] == TIMEOUT) begin
                            period_d[n*CW +: CW] = '0;
                            high_d[n*CW +: CW]   = '0;
                            timeout_d[n]         = 1'b1;
                            state_d[n]           = ST_IDLE;
                            cnt_d[n]             = '0;
                            hcnt_d[n]            = '0;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CW'(1);
                            if (samp_q[n] && !hdone_q[n] && (hcnt_q[n] != TIMEOUT)) begin
                                hcnt_d[n] = hcnt_q[n] + CW'(1);
                            end
                            if (fall_c[n]) begin
                                hlat_d[n]  = hcnt_q[n];
                                hdone_d[n] = 1'b1;
                            end
                        end
                    end
                    default: state_d[n] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int unsigned n = 0; n < NCHAN; n++) begin
                state_q[n] <= ST_IDLE;
                cnt_q[n]   <= '0;
                hcnt_q[n]  <= '0;
                hlat_q[n]  <= '0;
            end
            hdone_q   <= '0;
            samp_q    <= '0;
            prev_q    <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
            period_q  <= '0;
            high_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            hlat_q    <= hlat_d;
            hdone_q   <= hdone_d;
            samp_q    <= samp_d;
            prev_q    <= prev_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            period_q  <= period_d;
            high_q    <= high_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule
